gvp_stream_packer: RTL and testbench
====================================

Name: gvp_stream_packer

Overview:
- Sits directly downstream of the GVP execution core.
- Watches the GVP `store_data` trigger and snapshots the selected data sources, plus GVP index, time and options.
- Serialises each snapshot into a framed packet of 32-bit words, buffers it in a FIFO and drives one AXI-Stream master toward the DMA.
- Asserts `stall` back to the GVP core when buffer headroom is low, so the core pauses instead of losing samples.

Parameters:
- NUM_CH, 8, number of 32-bit data source channels.
- FIFO_DEPTH_N2, 6, log2 of FIFO depth in words (64).
- MAX_PKT, 13, worst-case packet length in words (1 header + 4 full-header words + NUM_CH).

Ports:
- a_clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- store_data  in  2  GVP store trigger: 0 none, 1 data point, 2 section start (full header), 3 program end (full header + end mark).
- options  in  32  GVP section options; options[16+NUM_CH-1:16] is the channel select mask.
- gvp_index  in  32  GVP point index.
- gvp_time  in  48  GVP time counter.
- src_data  in  NUM_CH*32  channel c at bits [32c+31:32c].
- M_AXIS_tdata  out  32  packet word.
- M_AXIS_tvalid  out  1  word valid.
- M_AXIS_tready  in  1  downstream accept.
- M_AXIS_tlast  out  1  last word of packet.
- stall  out  1  to GVP `stall` input.
- overflow  out  1  sticky; set when a trigger was dropped.
- drop_count  out  32  count of dropped triggers, saturating at 0xFFFFFFFF.
- fifo_level  out  FIFO_DEPTH_N2+1  words currently buffered.

Behaviour:
- Reset values: tvalid 0, tlast 0, tdata 0, stall 0, overflow 0, drop_count 0, fifo_level 0.
  - On reset: FIFO flushed, serialiser IDLE, prev_store 0, prev_index 0.
- Trigger detect:
  - Condition: trig = (store_data != 0) && ({store_data, gvp_index} != {prev_store, prev_index}).
  - prev_store and prev_index are registered every clock.
  - Consequence: a store value held for many clocks (GVP decimation) yields exactly one trigger.
- Packet length:
  - len = 1 + (store_data >= 2 ? 4 : 0) + popcount(mask).
- Accept vs drop:
  - A trigger is accepted only if the serialiser is IDLE and FIFO free space >= len.
  - Otherwise it is dropped: overflow is set, drop_count is incremented, and no words are written.
- Capture (edge ending trigger cycle T):
  - Registers store, mask, gvp_index, gvp_time, options and all src_data.
  - Serialiser goes IDLE -> HDR.
- Serialiser FSM, one FIFO write per clock; word k is written at the edge ending cycle T+1+k:
  - HDR: write {store[1:0], 6'b0, len[7:0], index[15:0]}.
    - If store >= 2, go to FULL; otherwise go to DATA, or to IDLE if the mask is 0.
  - FULL: 4 words: index[31:0], time[31:0], {16'h0, time[47:32]}, options.
    - Then go to DATA, or to IDLE if the mask is 0.
  - DATA: selected channels in ascending channel order, one per clock.
    - Go to IDLE after the highest selected channel.
  - tlast is stored in the FIFO as bit 32 and is set on the final word of each packet.
    - A header-only packet (mask 0, store 1) has tlast on the header word.
  - store 3 is packed like store 2; GVP forces options = all ones, so every channel is emitted.
- FIFO:
  - First-word-fall-through, FIFO_DEPTH words x 33 bits.
  - Empty FIFO case: tvalid rises in cycle T+2.
  - A word is popped when tvalid && tready.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - tdata and tlast are held stable while tvalid && !tready.
- stall:
  - Registered; stall = 1 when free space < 2*MAX_PKT or the serialiser is busy, else 0.
  - One clock latency.
- Reset mid-packet: the partial packet is discarded (FIFO flushed); the downstream receiver resynchronises on the next header.
- drop_count and overflow clear only on reset.

Decomposition:
- Shared package gvp_pkg:
  - store codes (STORE_NONE=0, STORE_DATA=1, STORE_HDR=2, STORE_END=3);
  - header bit positions;
  - FULL word count 4;
  - options mask offset 16.
- Sub-module gvp_sync_fifo:
  - parameterised width and depth, FWFT;
  - outputs level, full, empty.

Test Plan:
- Reset, then store_data=1, index=5, mask=0x05, ch0=0x11, ch2=0x33 -> words 0x4003_0005, 0x11, 0x33; tlast on 0x33; first tvalid at T+2.
- store_data=2, index=0x0001_0007, time=0x1234_89ABCDEF, options=0x00FF_0000 -> 13 words: header 0x800D_0007, 0x0001_0007, 0x89ABCDEF, 0x0000_1234, 0x00FF_0000, then ch0..ch7.
- store_data held at 1 for 10 clocks with constant index, then index changes -> exactly 2 packets.
- M_AXIS_tready=0, triggers every 14 clocks with 13-word packets -> stall rises once fewer than 26 words are free; the first trigger that does not fit gives overflow=1, drop_count=1; FIFO content is intact.
- Two triggers 2 clocks apart with mask=0xFF -> second dropped (serialiser busy), drop_count=1.
- Reset asserted mid-packet while tready=1 -> tvalid 0 next cycle, fifo_level 0, drop_count 0; next trigger packs normally.

Source files
------------

// File: rtl/gvp_pkg.sv
// Shared definitions for the GVP stream packer: store codes, header layout,
// full-header size and the option-mask location.
package gvp_pkg;

  typedef enum logic [1:0] {
    STORE_NONE = 2'd0,
    STORE_DATA = 2'd1,
    STORE_HDR  = 2'd2,
    STORE_END  = 2'd3
  } store_t;

  localparam int HDR_STORE_LSB = 30;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_IDX_LSB   = 0;
  localparam int FULL_WORDS    = 4;
  localparam int OPT_MASK_OFS  = 16;

  function automatic logic [7:0] popcount32(input logic [31:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < 32; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] make_hdr(input logic [1:0] store,
                                           input logic [7:0] len,
                                           input logic [15:0] idx);
    logic [31:0] h;
    h = '0;
    h[HDR_STORE_LSB +: 2] = store;
    h[HDR_LEN_LSB +: 8]   = len;
    h[HDR_IDX_LSB +: 16]  = idx;
    return h;
  endfunction

endpackage

// File: rtl/gvp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on
// rd_data whenever the FIFO is not empty.
module gvp_sync_fifo #(
  parameter int WIDTH    = 33,
  parameter int DEPTH_N2 = 6
) (
  input  logic                a_clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic [DEPTH_N2:0]   level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_N2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_N2-1:0] wr_ptr;
  logic [DEPTH_N2-1:0] rd_ptr;
  logic                push;
  logic                pop;

  assign full  = (level == (DEPTH_N2+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Head word reads as zero when empty so tdata is clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge a_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/gvp_stream_packer.sv
// Snapshots GVP store events into framed 32-bit packets, buffers them and
// streams them out over AXI-Stream, pausing the core when headroom runs low.
//
//   state  | meaning
//   S_IDLE | waiting for a trigger that fits in the FIFO
//   S_HDR  | writing the header word
//   S_FULL | writing the 4 full-header words (index, time lo, time hi, options)
//   S_DATA | writing selected channels, lowest channel first
module gvp_stream_packer
  import gvp_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int FIFO_DEPTH_N2 = 6,
  parameter int MAX_PKT       = 13
) (
  input  logic                     a_clk,
  input  logic                     reset,
  input  logic [1:0]               store_data,
  input  logic [31:0]              options,
  input  logic [31:0]              gvp_index,
  input  logic [47:0]              gvp_time,
  input  logic [NUM_CH*32-1:0]     src_data,
  output logic [31:0]              M_AXIS_tdata,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic                     M_AXIS_tlast,
  output logic                     stall,
  output logic                     overflow,
  output logic [31:0]              drop_count,
  output logic [FIFO_DEPTH_N2:0]   fifo_level
);

  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_N2;
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_FULL, S_DATA} state_t;

  state_t            state;
  logic [1:0]        prev_store;
  logic [31:0]       prev_index;
  logic [1:0]        cap_store;
  logic [7:0]        cap_len;
  logic [31:0]       cap_index;
  logic [47:0]       cap_time;
  logic [31:0]       cap_opts;
  logic [31:0]       cap_ch [NUM_CH];
  logic [NUM_CH-1:0] rem_mask;
  logic [NUM_CH-1:0] rem_next;
  logic [CW-1:0]     sel;
  logic [1:0]        full_cnt;

  logic [NUM_CH-1:0] mask;
  logic [7:0]        len;
  logic [31:0]       free_words;
  logic              trig;
  logic              accept;
  logic              drop;

  logic              wr_en;
  logic [31:0]       wr_word;
  logic              wr_last;
  logic              fifo_full;
  logic              fifo_empty;

  assign mask       = options[OPT_MASK_OFS +: NUM_CH];
  assign len        = 8'd1 + ((store_data >= STORE_HDR) ? 8'(FULL_WORDS) : 8'd0)
                      + popcount32(32'(mask));
  assign free_words = 32'(FIFO_DEPTH) - 32'(fifo_level);
  // A held store (decimation) repeats the same {store, index} and must not retrigger.
  assign trig   = (store_data != STORE_NONE) &&
                  ({store_data, gvp_index} != {prev_store, prev_index});
  assign accept = trig && (state == S_IDLE) && (free_words >= 32'(len));
  assign drop   = trig && !accept;

  always_ff @(posedge a_clk) begin
    if (reset) begin
      prev_store <= '0;
      prev_index <= '0;
    end else begin
      prev_store <= store_data;
      prev_index <= gvp_index;
    end
  end

  always_comb begin
    sel = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (rem_mask[c]) sel = CW'(c);
    end
    rem_next = rem_mask & ~(NUM_CH'(1) << sel);
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cap_store <= '0;
      cap_len   <= '0;
      cap_index <= '0;
      cap_time  <= '0;
      cap_opts  <= '0;
      rem_mask  <= '0;
      full_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) cap_ch[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_store <= store_data;
            cap_len   <= len;
            cap_index <= gvp_index;
            cap_time  <= gvp_time;
            cap_opts  <= options;
            rem_mask  <= mask;
            full_cnt  <= 2'(FULL_WORDS - 1);
            for (int c = 0; c < NUM_CH; c++) cap_ch[c] <= src_data[32*c +: 32];
            state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (cap_store >= STORE_HDR) state <= S_FULL;
          else if (rem_mask == '0)    state <= S_IDLE;
          else                        state <= S_DATA;
        end
        S_FULL: begin
          if (full_cnt == 2'd0) state <= (rem_mask == '0) ? S_IDLE : S_DATA;
          else                  full_cnt <= full_cnt - 2'd1;
        end
        S_DATA: begin
          rem_mask <= rem_next;
          if (rem_next == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en   = (state != S_IDLE) && !fifo_full;
    wr_word = '0;
    wr_last = 1'b0;
    case (state)
      S_HDR: begin
        wr_word = make_hdr(cap_store, cap_len, cap_index[15:0]);
        wr_last = (cap_store < STORE_HDR) && (rem_mask == '0);
      end
      S_FULL: begin
        case (full_cnt)
          2'd3:    wr_word = cap_index;
          2'd2:    wr_word = cap_time[31:0];
          2'd1:    wr_word = {16'h0, cap_time[47:32]};
          default: wr_word = cap_opts;
        endcase
        wr_last = (full_cnt == 2'd0) && (rem_mask == '0);
      end
      S_DATA: begin
        wr_word = cap_ch[sel];
        wr_last = (rem_next == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      stall      <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
      end
      stall <= (free_words < 32'(2 * MAX_PKT)) || (state != S_IDLE);
    end
  end

  gvp_sync_fifo #(
    .WIDTH    (33),
    .DEPTH_N2 (FIFO_DEPTH_N2)
  ) u_fifo (
    .a_clk   (a_clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({wr_last, wr_word}),
    .rd_en   (M_AXIS_tready),
    .rd_data ({M_AXIS_tlast, M_AXIS_tdata}),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign M_AXIS_tvalid = !fifo_empty;

endmodule

// File: tb/tb_gvp_stream_packer.sv
// Directed bench for gvp_stream_packer: packet vector table plus hand-written
// sequences for held stores, back-pressure, busy drops and mid-packet reset.
module tb_gvp_stream_packer;

  logic         a_clk = 1'b0;
  logic         reset;
  logic [1:0]   store_data;
  logic [31:0]  options;
  logic [31:0]  gvp_index;
  logic [47:0]  gvp_time;
  logic [255:0] src_data;
  logic [31:0]  M_AXIS_tdata;
  logic         M_AXIS_tvalid;
  logic         M_AXIS_tready;
  logic         M_AXIS_tlast;
  logic         stall;
  logic         overflow;
  logic [31:0]  drop_count;
  logic [6:0]   fifo_level;

  gvp_stream_packer #(.NUM_CH(8), .FIFO_DEPTH_N2(6), .MAX_PKT(13)) dut (
    .a_clk         (a_clk),
    .reset         (reset),
    .store_data    (store_data),
    .options       (options),
    .gvp_index     (gvp_index),
    .gvp_time      (gvp_time),
    .src_data      (src_data),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .stall         (stall),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  always #5 a_clk = ~a_clk;

  typedef struct packed {
    logic [1:0]     st;
    logic [31:0]    idx;
    logic [47:0]    tm;
    logic [31:0]    opt;
    logic [4:0]     n;
    logic [415:0]   w;   // word 0 in the top 32 bits
  } vec_t;

  localparam logic [255:0] CH_WORDS = {32'h88, 32'h77, 32'h66, 32'h55,
                                       32'h44, 32'h33, 32'h22, 32'h11};

  vec_t        vecs [7];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_data [$];
  logic        q_last [$];

  always @(negedge a_clk) begin
    if (!reset && M_AXIS_tvalid && M_AXIS_tready) begin
      q_data.push_back(M_AXIS_tdata);
      q_last.push_back(M_AXIS_tlast);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset      = 1'b1;
    store_data = 2'd0;
    tick();
    reset = 1'b0;
    q_data.delete();
    q_last.delete();
  endtask

  task automatic wait_words(input int n, input int budget);
    int b;
    b = 0;
    while (q_data.size() < n && b < budget) begin
      @(negedge a_clk);
      b++;
    end
    repeat (3) @(negedge a_clk);
  endtask

  task automatic check_vec(input int i);
    int n;
    int m;
    logic [415:0] w;
    n = int'(vecs[i].n);
    w = vecs[i].w;
    q_data.delete();
    q_last.delete();
    tick();
    store_data = vecs[i].st;
    gvp_index  = vecs[i].idx;
    gvp_time   = vecs[i].tm;
    options    = vecs[i].opt;
    @(negedge a_clk);
    check($sformatf("v%0d tvalid T", i), 32'(M_AXIS_tvalid), 32'd0);
    tick();
    store_data = 2'd0;
    @(negedge a_clk);
    check($sformatf("v%0d tvalid T+1", i), 32'(M_AXIS_tvalid), 32'd0);
    check($sformatf("v%0d stall T+1", i), 32'(stall), 32'd0);
    @(negedge a_clk);
    check($sformatf("v%0d tvalid T+2", i), 32'(M_AXIS_tvalid), 32'd1);
    check($sformatf("v%0d stall T+2", i), 32'(stall), 32'd1);
    wait_words(n, 40);
    check($sformatf("v%0d word count", i), 32'(q_data.size()), 32'(n));
    m = (q_data.size() < n) ? q_data.size() : n;
    for (int k = 0; k < m; k++) begin
      check($sformatf("v%0d w%0d data", i, k), q_data[k], w[(12-k)*32 +: 32]);
      check($sformatf("v%0d w%0d tlast", i, k), 32'(q_last[k]), 32'(k == n - 1));
    end
  endtask

  initial begin
    vecs[0] = '{st: 2'd1, idx: 32'h5, tm: 48'h0, opt: 32'h0005_0000, n: 5'd3,
                w: {32'h4003_0005, 32'h11, 32'h33, {10{32'h0}}}};
    vecs[1] = '{st: 2'd2, idx: 32'h0001_0007, tm: 48'h1234_89AB_CDEF, opt: 32'h00FF_0000,
                n: 5'd13, w: {32'h800D_0007, 32'h0001_0007, 32'h89AB_CDEF, 32'h0000_1234,
                              32'h00FF_0000, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55,
                              32'h66, 32'h77, 32'h88}};
    vecs[2] = '{st: 2'd1, idx: 32'h20, tm: 48'h0, opt: 32'h0000_1234, n: 5'd1,
                w: {32'h4001_0020, {12{32'h0}}}};
    vecs[3] = '{st: 2'd2, idx: 32'hA, tm: 48'h55, opt: 32'h0000_00AB, n: 5'd5,
                w: {32'h8005_000A, 32'h0000_000A, 32'h0000_0055, 32'h0, 32'h0000_00AB,
                    {8{32'h0}}}};
    vecs[4] = '{st: 2'd1, idx: 32'h0003_0030, tm: 48'h0, opt: 32'h0080_0000, n: 5'd2,
                w: {32'h4002_0030, 32'h88, {11{32'h0}}}};
    vecs[5] = '{st: 2'd3, idx: 32'h0000_FFFF, tm: 48'hAAAA_0000_0001, opt: 32'hFFFF_FFFF,
                n: 5'd13, w: {32'hC00D_FFFF, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_AAAA,
                              32'hFFFF_FFFF, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55,
                              32'h66, 32'h77, 32'h88}};
    vecs[6] = '{st: 2'd1, idx: 32'h41, tm: 48'h0, opt: 32'h0081_0000, n: 5'd3,
                w: {32'h4003_0041, 32'h11, 32'h88, {10{32'h0}}}};

    reset         = 1'b1;
    store_data    = 2'd0;
    options       = '0;
    gvp_index     = '0;
    gvp_time      = '0;
    src_data      = CH_WORDS;
    M_AXIS_tready = 1'b1;
    tick();
    do_reset();
    @(negedge a_clk);
    check("rst tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("rst tlast", 32'(M_AXIS_tlast), 32'd0);
    check("rst tdata", M_AXIS_tdata, 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst drop_count", drop_count, 32'd0);
    check("rst fifo_level", 32'(fifo_level), 32'd0);

    for (int i = 0; i < 7; i++) check_vec(i);

    // Held store: one packet per distinct {store, index}
    q_data.delete();
    q_last.delete();
    options = 32'h0001_0000;
    for (int c = 0; c < 30; c++) begin
      tick();
      store_data = (c < 13) ? 2'd1 : 2'd0;
      gvp_index  = (c < 10) ? 32'h77 : 32'h78;
    end
    wait_words(4, 10);
    check("hold word count", 32'(q_data.size()), 32'd4);
    if (q_data.size() >= 4) begin
      check("hold w0", q_data[0], 32'h4002_0077);
      check("hold w1", q_data[1], 32'h11);
      check("hold w2", q_data[2], 32'h4002_0078);
      check("hold w3", q_data[3], 32'h11);
      check("hold tlast1", 32'(q_last[1]), 32'd1);
      check("hold tlast3", 32'(q_last[3]), 32'd1);
    end
    check("hold drop_count", drop_count, 32'd0);

    // Back-pressure: fill the FIFO with 13-word packets until one no longer fits
    do_reset();
    M_AXIS_tready = 1'b0;
    options  = 32'h00FF_0000;
    gvp_time = 48'h0005_0000_0009;
    for (int k = 1; k <= 5; k++) begin
      tick();
      store_data = 2'd2;
      gvp_index  = 32'h100 + 32'(k);
      tick();
      store_data = 2'd0;
      repeat (14) tick();
      @(negedge a_clk);
      check($sformatf("bp%0d level", k), 32'(fifo_level), 32'(13 * ((k < 4) ? k : 4)));
      check($sformatf("bp%0d stall", k), 32'(stall), 32'(k >= 3));
      check($sformatf("bp%0d overflow", k), 32'(overflow), 32'(k >= 5));
      check($sformatf("bp%0d drop_count", k), drop_count, (k >= 5) ? 32'd1 : 32'd0);
    end
    check("bp tdata held", M_AXIS_tdata, 32'h800D_0101);
    M_AXIS_tready = 1'b1;
    wait_words(52, 80);
    check("bp word count", 32'(q_data.size()), 32'd52);
    if (q_data.size() >= 52) begin
      for (int j = 0; j < 52; j++) begin
        logic [31:0] e;
        int p;
        int wi;
        p  = j / 13;
        wi = j % 13;
        case (wi)
          0:       e = 32'h800D_0000 | (32'h101 + 32'(p));
          1:       e = 32'h101 + 32'(p);
          2:       e = 32'h9;
          3:       e = 32'h5;
          4:       e = 32'h00FF_0000;
          default: e = 32'h11 * 32'(wi - 4);
        endcase
        check($sformatf("bp w%0d data", j), q_data[j], e);
        check($sformatf("bp w%0d tlast", j), 32'(q_last[j]), 32'(wi == 12));
      end
    end
    check("bp drained level", 32'(fifo_level), 32'd0);

    // Second trigger while serialiser busy is dropped
    do_reset();
    options = 32'h00FF_0000;
    tick();
    store_data = 2'd1;
    gvp_index  = 32'h50;
    tick();
    store_data = 2'd0;
    tick();
    store_data = 2'd1;
    gvp_index  = 32'h51;
    tick();
    store_data = 2'd0;
    wait_words(9, 30);
    check("busy drop_count", drop_count, 32'd1);
    check("busy overflow", 32'(overflow), 32'd1);
    check("busy word count", 32'(q_data.size()), 32'd9);
    if (q_data.size() >= 9) begin
      check("busy header", q_data[0], 32'h4009_0050);
      check("busy ch7", q_data[8], 32'h88);
      check("busy tlast", 32'(q_last[8]), 32'd1);
    end

    // Reset in the middle of a packet
    tick();
    store_data = 2'd2;
    gvp_index  = 32'h60;
    tick();
    store_data = 2'd0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge a_clk);
    check("midrst tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("midrst fifo_level", 32'(fifo_level), 32'd0);
    check("midrst drop_count", drop_count, 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    check("midrst stall", 32'(stall), 32'd0);
    check_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
